// File: rtl/alien_calc_input_pkg.sv
// Shared types and constants for the alien calculator input stage and the
// downstream arithmetic/display stages.
package alien_calc_pkg;

  localparam int CALC_WIDTH              = 2;
  localparam int DEFAULT_WIDTH           = 5;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } enter_state_e;

  typedef enum logic [CALC_WIDTH-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } calc_op_e;

  // Debounce counter width; the clamp keeps the counter at least one bit wide.
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/alien_calc_input_sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous inputs.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/alien_calc_input.sv
// Synchronizes operand/opcode switches, debounces Enter, and on each clean
// press freezes the switches into output registers with a one-cycle valid.
module alien_calc_input
  import alien_calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int WIDTH           = DEFAULT_WIDTH
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [WIDTH-1:0]      i_A,
  input  logic [WIDTH-1:0]      i_B,
  input  logic [CALC_WIDTH-1:0] i_Calc,
  input  logic                  i_Enter,
  input  logic                  i_Clear,
  output logic [WIDTH-1:0]      o_A,
  output logic [WIDTH-1:0]      o_B,
  output logic [CALC_WIDTH-1:0] o_Calc,
  output logic                  o_Valid,
  output logic                  o_Held
);

  localparam int SYNC_W = 2 * WIDTH + CALC_WIDTH + 2;
  localparam int CNT_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_W-1:0]     raw_bus;
  logic [SYNC_W-1:0]     sync_bus;
  logic [WIDTH-1:0]      a_s;
  logic [WIDTH-1:0]      b_s;
  logic [CALC_WIDTH-1:0] calc_s;
  logic                  enter_s;
  logic                  clear_s;

  enter_state_e          state;
  logic [CNT_W-1:0]      cnt;
  logic                  capture;

  assign raw_bus = {i_Clear, i_Enter, i_Calc, i_B, i_A};

  sync_2ff #(
    .WIDTH(SYNC_W)
  ) u_sync (
    .clk  (sys_clk),
    .rst_n(sys_rst_n),
    .d    (raw_bus),
    .q    (sync_bus)
  );

  assign {clear_s, enter_s, calc_s, b_s, a_s} = sync_bus;

  assign capture = (state == ST_PRESS) && enter_s && (cnt == CNT_LAST);

  // Clear overrides the output registers but never the FSM, so a press that
  // coincides with Clear is still consumed and needs a release to re-arm.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      o_A     <= '0;
      o_B     <= '0;
      o_Calc  <= '0;
      o_Valid <= 1'b0;
      o_Held  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enter_s) begin
            cnt   <= CNT_ONE;
            state <= ST_PRESS;
          end
        end
        ST_PRESS: begin
          if (!enter_s) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= ST_HELD;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_HELD: begin
          if (!enter_s) begin
            cnt   <= CNT_ONE;
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (enter_s) begin
            cnt   <= '0;
            state <= ST_HELD;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase

      o_Valid <= 1'b0;
      if (clear_s) begin
        o_A    <= '0;
        o_B    <= '0;
        o_Calc <= '0;
        o_Held <= 1'b0;
      end else if (capture) begin
        o_A     <= a_s;
        o_B     <= b_s;
        o_Calc  <= calc_s;
        o_Held  <= 1'b1;
        o_Valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alien_calc_input.sv
// Self-checking bench for alien_calc_input: directed scenarios plus random
// switch/button traffic, compared every cycle against a debounce-level model.
module tb_alien_calc_input;
  import alien_calc_pkg::*;

  localparam int D = 4;
  localparam int W = 5;

  logic                  sys_clk = 1'b0;
  logic                  sys_rst_n = 1'b0;
  logic [W-1:0]          i_A = '0;
  logic [W-1:0]          i_B = '0;
  logic [CALC_WIDTH-1:0] i_Calc = '0;
  logic                  i_Enter = 1'b0;
  logic                  i_Clear = 1'b0;
  logic [W-1:0]          o_A;
  logic [W-1:0]          o_B;
  logic [CALC_WIDTH-1:0] o_Calc;
  logic                  o_Valid;
  logic                  o_Held;

  alien_calc_input #(
    .DEBOUNCE_CYCLES(D),
    .WIDTH          (W)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .i_A      (i_A),
    .i_B      (i_B),
    .i_Calc   (i_Calc),
    .i_Enter  (i_Enter),
    .i_Clear  (i_Clear),
    .o_A      (o_A),
    .o_B      (o_B),
    .o_Calc   (o_Calc),
    .o_Valid  (o_Valid),
    .o_Held   (o_Held)
  );

  always #5 sys_clk = ~sys_clk;

  int edge_cnt = 0;
  always @(posedge sys_clk) edge_cnt++;

  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;
  int last_valid_edge = -1;

  // Reference: switches reach the logic two edges late; the button's debounced
  // level flips after D consecutive equal samples, and a 0->1 flip is a capture.
  typedef struct packed {
    logic                  clear;
    logic                  enter;
    logic [CALC_WIDTH-1:0] calc;
    logic [W-1:0]          b;
    logic [W-1:0]          a;
  } sw_t;

  sw_t                   seen [2];
  sw_t                   raw_now;
  sw_t                   s_now;
  int                    ones_run;
  int                    zeros_run;
  bit                    debounced;
  bit                    press_now;
  logic [W-1:0]          m_a;
  logic [W-1:0]          m_b;
  logic [CALC_WIDTH-1:0] m_calc;
  logic                  m_valid;
  logic                  m_held;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      seen[0]   = '0;
      seen[1]   = '0;
      ones_run  = 0;
      zeros_run = 0;
      debounced = 1'b0;
      m_a       = '0;
      m_b       = '0;
      m_calc    = '0;
      m_valid   = 1'b0;
      m_held    = 1'b0;
    end else begin
      raw_now = '{clear: i_Clear, enter: i_Enter, calc: i_Calc, b: i_B, a: i_A};
      s_now   = seen[1];
      seen[1] = seen[0];
      seen[0] = raw_now;
      if (s_now.enter) begin
        ones_run++;
        zeros_run = 0;
      end else begin
        zeros_run++;
        ones_run = 0;
      end
      press_now = 1'b0;
      if (!debounced && ones_run == D) begin
        debounced = 1'b1;
        press_now = 1'b1;
      end else if (debounced && zeros_run == D) begin
        debounced = 1'b0;
      end
      m_valid = 1'b0;
      if (s_now.clear) begin
        m_a    = '0;
        m_b    = '0;
        m_calc = '0;
        m_held = 1'b0;
      end else if (press_now) begin
        m_a     = s_now.a;
        m_b     = s_now.b;
        m_calc  = s_now.calc;
        m_held  = 1'b1;
        m_valid = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at edge %0d",
               tag, actual, expected, edge_cnt);
    end
  endtask

  // Drives one input set for n cycles; each cycle is sampled by one rising
  // edge and all outputs are compared on the following falling edge.
  task automatic applyStimulus(input logic enter, input logic clear,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [CALC_WIDTH-1:0] calc, input int n);
    for (int i = 0; i < n; i++) begin
      i_Enter = enter;
      i_Clear = clear;
      i_A     = a;
      i_B     = b;
      i_Calc  = calc;
      @(negedge sys_clk);
      checkOutput("o_A", 32'(o_A), 32'(m_a));
      checkOutput("o_B", 32'(o_B), 32'(m_b));
      checkOutput("o_Calc", 32'(o_Calc), 32'(m_calc));
      checkOutput("o_Valid", 32'(o_Valid), 32'(m_valid));
      checkOutput("o_Held", 32'(o_Held), 32'(m_held));
      if (o_Valid) begin
        valid_cnt++;
        last_valid_edge = edge_cnt;
      end
    end
  endtask

  task automatic releaseAll(input int n);
    applyStimulus(1'b0, 1'b0, W'($urandom), W'($urandom), CALC_WIDTH'($urandom), n);
  endtask

  int k;
  int v0;
  int r;

  initial begin
    // Power-on reset
    repeat (2) @(negedge sys_clk);
    checkOutput("por_o_A", 32'(o_A), 32'h0);
    checkOutput("por_o_Held", 32'(o_Held), 32'h0);
    checkOutput("por_o_Valid", 32'(o_Valid), 32'h0);
    sys_rst_n = 1'b1;
    releaseAll(6);

    // Clean press
    v0 = valid_cnt;
    k  = edge_cnt + 1;
    applyStimulus(1'b1, 1'b0, 5'h13, 5'h07, 2'b10, 20);
    checkOutput("clean_pulses", 32'(valid_cnt - v0), 32'd1);
    checkOutput("clean_latency", 32'(last_valid_edge), 32'(k + D + 1));
    checkOutput("clean_a", 32'(o_A), 32'h13);
    checkOutput("clean_b", 32'(o_B), 32'h07);
    checkOutput("clean_calc", 32'(o_Calc), 32'h2);
    checkOutput("clean_held", 32'(o_Held), 32'h1);
    releaseAll(6);

    // Bounce 1,0,1,1,0 then steady high
    v0 = valid_cnt;
    applyStimulus(1'b1, 1'b0, 5'h0A, 5'h15, 2'b01, 1);
    applyStimulus(1'b0, 1'b0, 5'h0A, 5'h15, 2'b01, 1);
    applyStimulus(1'b1, 1'b0, 5'h0A, 5'h15, 2'b01, 2);
    applyStimulus(1'b0, 1'b0, 5'h0A, 5'h15, 2'b01, 1);
    checkOutput("bounce_no_capture", 32'(valid_cnt - v0), 32'd0);
    k = edge_cnt + 1;
    applyStimulus(1'b1, 1'b0, 5'h0A, 5'h15, 2'b01, 12);
    checkOutput("bounce_pulses", 32'(valid_cnt - v0), 32'd1);
    checkOutput("bounce_latency", 32'(last_valid_edge), 32'(k + D + 1));
    checkOutput("bounce_a", 32'(o_A), 32'h0A);
    releaseAll(6);

    // Hold, short release, re-press, then a debounced release and press
    v0 = valid_cnt;
    applyStimulus(1'b1, 1'b0, 5'h13, 5'h07, 2'b11, 8);
    applyStimulus(1'b1, 1'b0, 5'h1F, 5'h07, 2'b11, 3);
    applyStimulus(1'b0, 1'b0, 5'h1F, 5'h07, 2'b11, 1);
    applyStimulus(1'b1, 1'b0, 5'h1F, 5'h07, 2'b11, 6);
    checkOutput("hold_single_capture", 32'(valid_cnt - v0), 32'd1);
    checkOutput("hold_a_frozen", 32'(o_A), 32'h13);
    applyStimulus(1'b0, 1'b0, 5'h1F, 5'h07, 2'b11, 5);
    applyStimulus(1'b1, 1'b0, 5'h1F, 5'h07, 2'b11, 8);
    checkOutput("repress_pulses", 32'(valid_cnt - v0), 32'd2);
    checkOutput("repress_a", 32'(o_A), 32'h1F);

    // Clear while held
    applyStimulus(1'b1, 1'b1, 5'h1F, 5'h07, 2'b11, 3);
    applyStimulus(1'b1, 1'b0, 5'h1F, 5'h07, 2'b11, 3);
    checkOutput("clear_a", 32'(o_A), 32'h0);
    checkOutput("clear_held", 32'(o_Held), 32'h0);
    releaseAll(6);

    // Re-establish held state, then Clear landing exactly on the capture edge
    applyStimulus(1'b1, 1'b0, 5'h11, 5'h02, 2'b01, 8);
    releaseAll(6);
    v0 = valid_cnt;
    applyStimulus(1'b1, 1'b0, 5'h09, 5'h03, 2'b10, 3);
    applyStimulus(1'b1, 1'b1, 5'h09, 5'h03, 2'b10, 1);
    applyStimulus(1'b1, 1'b0, 5'h09, 5'h03, 2'b10, 10);
    checkOutput("coincident_no_valid", 32'(valid_cnt - v0), 32'd0);
    checkOutput("coincident_held", 32'(o_Held), 32'h0);
    checkOutput("coincident_a", 32'(o_A), 32'h0);
    releaseAll(6);
    applyStimulus(1'b1, 1'b0, 5'h09, 5'h03, 2'b10, 8);
    checkOutput("coincident_rearm", 32'(valid_cnt - v0), 32'd1);
    checkOutput("coincident_rearm_a", 32'(o_A), 32'h09);
    releaseAll(6);

    // Reset mid-PRESS with the counter at 2, button still held afterwards
    k = edge_cnt + 1;
    applyStimulus(1'b1, 1'b0, 5'h0C, 5'h1B, 2'b00, 4);
    #2 sys_rst_n = 1'b0;
    #1;
    checkOutput("rst_async_a", 32'(o_A), 32'h0);
    checkOutput("rst_async_held", 32'(o_Held), 32'h0);
    checkOutput("rst_async_valid", 32'(o_Valid), 32'h0);
    applyStimulus(1'b1, 1'b0, 5'h0C, 5'h1B, 2'b00, 2);
    sys_rst_n = 1'b1;
    v0 = valid_cnt;
    r  = edge_cnt + 1;
    applyStimulus(1'b1, 1'b0, 5'h0C, 5'h1B, 2'b00, 10);
    checkOutput("rst_repress_pulses", 32'(valid_cnt - v0), 32'd1);
    checkOutput("rst_repress_latency", 32'(last_valid_edge), 32'(r + D + 1));
    checkOutput("rst_repress_b", 32'(o_B), 32'h1B);

    // Random traffic
    for (int seg = 0; seg < 80; seg++) begin
      applyStimulus(1'($urandom), ($urandom_range(0, 9) == 0),
                    W'($urandom), W'($urandom), CALC_WIDTH'($urandom),
                    $urandom_range(1, 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
